ahb_apb4_bridge: RTL and testbench

AHB_APB4_BRIDGE -- requirements
Module: ahb_apb4_bridge

---
 rtl/ahb_apb_pkg.sv | 50 +++++
 rtl/apb_timeout_cnt.sv | 30 +++
 rtl/ahb_apb4_bridge.sv | 151 +++++++++++++++
 tb/tb_ahb_apb4_bridge.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and mapping helpers for the AHB-lite to APB4 bridge.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // NONSEQ and SEQ start a transfer; IDLE and BUSY never do.
    function automatic logic htrans_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

    // Byte lanes touched by a write; reads drive no strobes.
    function automatic logic [3:0] pstrb_map(input logic       write,
                                             input logic [2:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            3'd0:    strb = 4'b0001 << addr_lo;
            3'd1:    strb = 4'b0011 << addr_lo;
            default: strb = 4'b1111;
        endcase
        return write ? strb : 4'b0000;
    endfunction

    // {instruction, non-secure, privileged} from HPROT[1:0].
    function automatic logic [2:0] pprot_map(input logic [1:0] hprot);
        return {~hprot[0], 1'b0, hprot[1]};
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts PCLKEN-qualified ACCESS cycles and flags the last permitted one.
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic pclken,
    output logic expired
);

    localparam int unsigned    CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count;

    // Asserted during the TIMEOUT-th sampled ACCESS cycle; never when disabled.
    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

    // Counter advances once per APB-rate tick while the access is outstanding.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && pclken && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/ahb_apb4_bridge.sv
// AHB-lite slave to APB4 requester bridge with completer decode and timeout.
module ahb_apb4_bridge
    import ahb_apb_pkg::*;
#(
    parameter int unsigned NSLV    = 4,
    parameter int unsigned SEL_LSB = 12,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSEL,
    input  logic                 HREADY,
    input  logic [31:0]          HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [3:0]           HPROT,
    input  logic [31:0]          HWDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    input  logic                 PCLKEN,
    output logic [NSLV-1:0]      PSEL,
    output logic [31:0]          PADDR,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [32*NSLV-1:0]   PRDATA,
    input  logic [NSLV-1:0]      PREADY,
    input  logic [NSLV-1:0]      PSLVERR
);

    // Index field is one bit wider than strictly needed when NSLV is a power
    // of two, so addresses just above the last completer decode as errors.
    localparam int unsigned IDXW = $clog2(NSLV + 1);

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   idx;
    logic              idx_bad;
    logic              capture;
    logic [NSLV-1:0]   sel_onehot;
    logic [31:0]       prdata_sel;
    logic              pready_sel;
    logic              pslverr_sel;
    logic              expired;
    logic              hprot_unused;

    assign hprot_unused = ^HPROT[3:2];
    assign capture      = HSEL && HREADY && htrans_active(HTRANS);
    assign idx          = PADDR[SEL_LSB +: IDXW];
    assign idx_bad      = 32'(idx) >= NSLV;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (HCLK),
        .rst     (HRESET),
        .clear   (state != ST_ACCESS),
        .enable  (state == ST_ACCESS),
        .pclken  (PCLKEN),
        .expired (expired)
    );

    // Completer select and response multiplexing from the latched address.
    always_comb begin
        sel_onehot  = '0;
        prdata_sel  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (32'(idx) == i) begin
                sel_onehot[i] = 1'b1;
                prdata_sel    = PRDATA[32*i +: 32];
                pready_sel    = PREADY[i];
                pslverr_sel   = PSLVERR[i];
            end
        end
    end

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; APB phases advance only on PCLKEN ticks.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (capture) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (idx_bad)     state_next = ST_ERR1;
                else if (PCLKEN) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (PCLKEN) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PCLKEN) begin
                    if (pready_sel)   state_next = pslverr_sel ? ST_ERR1 : ST_IDLE;
                    else if (expired) state_next = ST_ERR1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            ST_ERR2: state_next = capture ? ST_WAIT : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered bus outputs, decoded from the upcoming state so they are glitch-free.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
        end else begin
            HREADYOUT <= (state_next == ST_IDLE) || (state_next == ST_ERR2);
            HRESP     <= ((state_next == ST_ERR1) || (state_next == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
            PSEL      <= ((state_next == ST_SETUP) || (state_next == ST_ACCESS)) ? sel_onehot : '0;
            PENABLE   <= (state_next == ST_ACCESS);
            if (((state == ST_IDLE) || (state == ST_ERR2)) && capture) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
                PSTRB  <= pstrb_map(HWRITE, HSIZE, HADDR[1:0]);
                PPROT  <= pprot_map(HPROT[1:0]);
            end
            if (state == ST_WAIT) begin
                PWDATA <= HWDATA;
            end
            if ((state == ST_ACCESS) && PCLKEN && pready_sel && !pslverr_sel && !PWRITE) begin
                HRDATA <= prdata_sel;
            end
        end
    end

endmodule

// File: tb/tb_ahb_apb4_bridge.sv
// Directed and randomized checks of ahb_apb4_bridge against a cycle-timeline model.
module tb_ahb_apb4_bridge;

    localparam int unsigned NSLV = 4;
    localparam int unsigned TMO  = 8;

    logic                HCLK = 1'b0;
    logic                HRESET;
    logic                HSEL;
    logic                HREADY;
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [3:0]          HPROT;
    logic [31:0]         HWDATA;
    logic                HREADYOUT;
    logic                HRESP;
    logic [31:0]         HRDATA;
    logic                PCLKEN;
    logic [NSLV-1:0]     PSEL;
    logic [31:0]         PADDR;
    logic                PWRITE;
    logic                PENABLE;
    logic [31:0]         PWDATA;
    logic [3:0]          PSTRB;
    logic [2:0]          PPROT;
    logic [32*NSLV-1:0]  PRDATA;
    logic [NSLV-1:0]     PREADY;
    logic [NSLV-1:0]     PSLVERR;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    bit          pclk_toggle = 1'b0;
    logic [31:0] hrdata_m = '0;

    ahb_apb4_bridge #(
        .NSLV    (NSLV),
        .SEL_LSB (12),
        .TIMEOUT (TMO)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HREADY    (HREADY),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HPROT     (HPROT),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PCLKEN    (PCLKEN),
        .PSEL      (PSEL),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit en_at(input int unsigned abs_cyc);
        return !pclk_toggle || (abs_cyc % 2 == 0);
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
        cyc++;
        PCLKEN = en_at(cyc);
    endtask

    task automatic drive_junk();
        HSEL   = 1'($urandom);
        HREADY = 1'($urandom);
        HTRANS = 2'($urandom);
        HADDR  = $urandom;
        HWRITE = 1'($urandom);
        HSIZE  = 3'($urandom);
        HPROT  = 4'($urandom);
    endtask

    // Random bus activity that must never start a transfer.
    task automatic drive_quiet();
        drive_junk();
        HREADY = 1'b1;
        if ($urandom % 2 == 0) HSEL = 1'b0;
        else                   HTRANS = {1'b0, 1'($urandom)};
    endtask

    task automatic randomize_apb();
        for (int i = 0; i < NSLV; i++) PRDATA[32*i +: 32] = $urandom;
        PREADY  = NSLV'($urandom);
        PSLVERR = NSLV'($urandom);
    endtask

    task automatic idle_gap(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            tick();
            chk("idle_hreadyout", 32'(HREADYOUT), 32'(1));
            chk("idle_hresp", 32'(HRESP), 32'(0));
            chk("idle_psel", 32'(PSEL), 32'(0));
            chk("idle_penable", 32'(PENABLE), 32'(0));
            drive_quiet();
            randomize_apb();
        end
    endtask

    // One AHB transfer starting in the current (IDLE or ERR2) cycle; ends in the
    // cycle where HREADYOUT returns high, leaving non-capturing inputs driven.
    task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                        input logic [3:0] prot, input logic [31:0] wdata,
                        input int unsigned waits, input bit slverr, input logic [31:0] rdata);
        int unsigned c0, s, a, d, last, need, n, idx;
        bit bad, err, tmo;
        logic [3:0] strb;
        logic [2:0] pprot;
        logic [NSLV-1:0] onehot;
        idx    = (addr / 4096) % 8;
        bad    = idx >= NSLV;
        onehot = bad ? '0 : NSLV'(1 << idx);
        strb   = wr ? 4'((size == 0 ? 1 : size == 1 ? 3 : 15) << (addr % 4)) : 4'h0;
        pprot  = {~prot[0], 1'b0, prot[1]};
        tmo    = !slverr && waits >= TMO;
        err    = bad || slverr || tmo;
        c0     = cyc;
        HSEL   = 1'b1;
        HREADY = 1'b1;
        HTRANS = ($urandom % 2 == 0) ? 2'b10 : 2'b11;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
        HPROT  = prot;
        if (bad) begin
            s = 1; a = 1; d = 1; last = 3;
        end else begin
            s = 1;
            while (!en_at(c0 + s)) s++;
            a = s + 1;
            while (!en_at(c0 + a)) a++;
            need = (waits >= TMO) ? TMO : waits + 1;
            d = a;
            n = 0;
            while (n < need) begin
                d++;
                if (en_at(c0 + d)) n++;
            end
            last = err ? d + 2 : d + 1;
        end
        for (int unsigned c = 1; c <= last; c++) begin
            tick();
            chk("hreadyout", 32'(HREADYOUT), 32'(c == last));
            chk("hresp", 32'(HRESP), 32'(err && c + 1 >= last));
            chk("psel", 32'(PSEL), (!bad && c > s && c <= d) ? 32'(onehot) : 32'(0));
            chk("penable", 32'(PENABLE), 32'(!bad && c > a && c <= d));
            if (!bad && c > s && c <= d) begin
                chk("paddr", PADDR, addr);
                chk("pwrite", 32'(PWRITE), 32'(wr));
                chk("pstrb", 32'(PSTRB), 32'(strb));
                chk("pprot", 32'(PPROT), 32'(pprot));
                if (wr) chk("pwdata", PWDATA, wdata);
            end
            if (c == last) begin
                if (!err && !wr) hrdata_m = rdata;
                chk("hrdata", HRDATA, hrdata_m);
                drive_quiet();
            end else begin
                drive_junk();
            end
            HWDATA = (c <= s) ? wdata : $urandom;
            randomize_apb();
            if (!bad && c > a && c <= d && en_at(c0 + c)) begin
                PREADY[idx]  = (c == d) && !tmo;
                PSLVERR[idx] = slverr;
                if (c == d) PRDATA[32*idx +: 32] = rdata;
            end
        end
    endtask

    initial begin
        logic [31:0] addr;
        logic [2:0]  size;
        int unsigned idx_r, lo, waits;
        bit          slverr;

        HRESET = 1'b1;
        PCLKEN = 1'b1;
        HWDATA = '0;
        PRDATA = '0;
        PREADY = '0;
        PSLVERR = '0;
        drive_quiet();
        tick();
        tick();
        chk("rst_hreadyout", 32'(HREADYOUT), 32'(1));
        chk("rst_hresp", 32'(HRESP), 32'(0));
        chk("rst_psel", 32'(PSEL), 32'(0));
        chk("rst_penable", 32'(PENABLE), 32'(0));
        chk("rst_paddr", PADDR, 32'(0));
        chk("rst_pwrite", 32'(PWRITE), 32'(0));
        chk("rst_pwdata", PWDATA, 32'(0));
        chk("rst_pstrb", 32'(PSTRB), 32'(0));
        chk("rst_pprot", 32'(PPROT), 32'(0));
        chk("rst_hrdata", HRDATA, 32'(0));
        HRESET = 1'b0;
        idle_gap(2);

        // Word write to completer 2, zero wait states.
        xfer(32'h0000_2000, 1'b1, 3'd2, 4'h3, 32'h1234_5678, 0, 1'b0, 32'h0);
        idle_gap(2);
        // Byte read from completer 1 with three wait states.
        xfer(32'h0000_1003, 1'b0, 3'd0, 4'h1, 32'hDEAD_BEEF, 3, 1'b0, 32'hAABB_CCDD);
        idle_gap(1);
        // Out-of-range completer index.
        xfer(32'h0000_5000, 1'b0, 3'd2, 4'h0, 32'h0, 0, 1'b0, 32'h0);
        idle_gap(1);
        // Completer error on completion, then timeout with PREADY held low.
        xfer(32'h0000_3004, 1'b1, 3'd2, 4'h2, 32'hCAFE_0001, 1, 1'b1, 32'h0);
        idle_gap(1);
        xfer(32'h0000_0008, 1'b0, 3'd2, 4'h0, 32'h0, TMO, 1'b0, 32'h5555_AAAA);
        idle_gap(1);

        // Half-rate APB with back-to-back writes.
        pclk_toggle = 1'b1;
        xfer(32'h0000_1010, 1'b1, 3'd1, 4'h2, 32'h0BAD_F00D, 1, 1'b0, 32'h0);
        xfer(32'h0000_3002, 1'b1, 3'd1, 4'h1, 32'h7777_8888, 0, 1'b0, 32'h0);
        idle_gap(2);
        pclk_toggle = 1'b0;

        // Reset asserted while the access is outstanding.
        HSEL   = 1'b1;
        HREADY = 1'b1;
        HTRANS = 2'b10;
        HADDR  = 32'h0000_1000;
        HWRITE = 1'b1;
        HSIZE  = 3'd2;
        HPROT  = 4'h0;
        tick();
        drive_junk();
        HWDATA = 32'h4242_4242;
        PREADY = '0;
        tick();
        drive_junk();
        PREADY = '0;
        tick();
        chk("rst_mid_penable_before", 32'(PENABLE), 32'(1));
        drive_junk();
        PREADY = '0;
        HRESET = 1'b1;
        tick();
        chk("rst_mid_psel", 32'(PSEL), 32'(0));
        chk("rst_mid_penable", 32'(PENABLE), 32'(0));
        chk("rst_mid_hreadyout", 32'(HREADYOUT), 32'(1));
        chk("rst_mid_hresp", 32'(HRESP), 32'(0));
        HRESET   = 1'b0;
        hrdata_m = '0;
        drive_quiet();
        idle_gap(2);

        for (int t = 0; t < 40; t++) begin
            idx_r  = $urandom_range(0, 5);
            size   = 3'($urandom_range(0, 2));
            lo     = (size == 0) ? $urandom_range(0, 3) : (size == 1) ? 2 * $urandom_range(0, 1) : 0;
            addr   = ($urandom & 32'hFFFF_8FFC) | (idx_r << 12) | lo;
            waits  = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, 3);
            slverr = ($urandom_range(0, 5) == 0);
            pclk_toggle = ($urandom_range(0, 2) == 0);
            xfer(addr, 1'($urandom), size, 4'($urandom), $urandom, waits, slverr, $urandom);
            if ($urandom % 2 == 0) idle_gap($urandom_range(1, 2));
        end
        pclk_toggle = 1'b0;
        idle_gap(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
